// File: rtl/mdio_mgmt_scheduler_if.sv
// Bundle of all scheduler-facing signals: host register-access port, poll
// control/status, and the frame-engine handshake.
//   slave  : scheduler view (takes host requests, drives the engine)
//   master : environment view (host, engine model, status consumers)
interface mdio_mgmt_scheduler_if;
  // host port
  logic        HOST_REQ;
  logic        HOST_WR;
  logic [4:0]  HOST_PHYAD;
  logic [4:0]  HOST_REGAD;
  logic [15:0] HOST_WDATA;
  logic        HOST_ACK;
  logic        HOST_DONE;
  logic [15:0] HOST_RDATA;
  logic        HOST_ERR;
  // poller
  logic        POLL_EN;
  logic        LINK_UP;
  logic        LINK_CHANGE;
  logic [15:0] POLL_DATA;
  // frame engine
  logic        ENG_START;
  logic [31:0] ENG_FRAME;
  logic        ENG_DONE;
  logic [15:0] ENG_RDATA;
  // status
  logic        BUSY;

  modport slave (
    input  HOST_REQ, HOST_WR, HOST_PHYAD, HOST_REGAD, HOST_WDATA, POLL_EN, ENG_DONE, ENG_RDATA,
    output HOST_ACK, HOST_DONE, HOST_RDATA, HOST_ERR, LINK_UP, LINK_CHANGE, POLL_DATA,
           ENG_START, ENG_FRAME, BUSY
  );

  modport master (
    output HOST_REQ, HOST_WR, HOST_PHYAD, HOST_REGAD, HOST_WDATA, POLL_EN, ENG_DONE, ENG_RDATA,
    input  HOST_ACK, HOST_DONE, HOST_RDATA, HOST_ERR, LINK_UP, LINK_CHANGE, POLL_DATA,
           ENG_START, ENG_FRAME, BUSY
  );
endinterface

// File: rtl/mdio_mgmt_scheduler.sv
// Clause-22 MDIO transaction scheduler. Round-robin arbitration between the
// host register port and a periodic link-status poller; builds the 32-bit
// frame, starts the frame engine, waits for completion or timeout and
// returns read data to the requester that won.
// Ports:
//   clk   : clock
//   RESET : synchronous, active-high reset
//   bus   : mdio_mgmt_scheduler_if.slave (host, poll status, engine handshake)
module mdio_mgmt_scheduler #(
  parameter int unsigned POLL_INTERVAL = 100000,
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [4:0]  POLL_PHYAD    = 5'd0,
  parameter logic [4:0]  POLL_REGAD    = 5'd1,
  parameter int unsigned LINK_BIT      = 2
) (
  input  logic                    clk,
  input  logic                    RESET,
  mdio_mgmt_scheduler_if.slave    bus
);

  localparam int unsigned PW = $clog2(POLL_INTERVAL);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LINK_IDX  = LINK_BIT[3:0];
  localparam logic [31:0]   POLL_FRAME = {2'b01, 2'b10, POLL_PHYAD, POLL_REGAD, 2'b10, 16'h0000};

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  state_e state_q, state_d;

  logic [PW-1:0] poll_cnt_q;
  logic          poll_pending_q;
  logic          last_host_q;   // 1: host won the last grant, 0: poller
  logic          owner_host_q;
  logic          owner_wr_q;
  logic [31:0]   frame_q;
  logic [TW-1:0] to_cnt_q;
  logic          host_done_q, host_err_q;
  logic [15:0]   host_rdata_q;
  logic          link_up_q, link_change_q;
  logic [15:0]   poll_data_q;

  logic grant_host, grant_poll, in_idle, to_last, eng_done_w, timeout_w;
  logic poll_expire;

  // Round robin: on contention the requester that did not win last time goes.
  assign grant_host  = bus.HOST_REQ && (!poll_pending_q || !last_host_q);
  assign grant_poll  = poll_pending_q && (!bus.HOST_REQ || last_host_q);
  assign in_idle     = (state_q == StIdle);
  assign to_last     = (to_cnt_q == TO_LAST);
  // Completion beats timeout when both land in the same cycle.
  assign eng_done_w  = (state_q == StWait) && bus.ENG_DONE;
  assign timeout_w   = (state_q == StWait) && !bus.ENG_DONE && to_last;
  assign poll_expire = (poll_cnt_q == POLL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_host || grant_poll) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.ENG_DONE || to_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ENG_START   = (state_q == StIssue);
    bus.HOST_ACK    = (state_q == StIssue) && owner_host_q;
    bus.BUSY        = (state_q != StIdle);
    bus.ENG_FRAME   = frame_q;
    bus.HOST_DONE   = host_done_q;
    bus.HOST_RDATA  = host_rdata_q;
    bus.HOST_ERR    = host_err_q;
    bus.LINK_UP     = link_up_q;
    bus.LINK_CHANGE = link_change_q;
    bus.POLL_DATA   = poll_data_q;
  end

  // Datapath: poll timer, grant latch, timeout counter, result registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      last_host_q    <= 1'b0;
      owner_host_q   <= 1'b0;
      owner_wr_q     <= 1'b0;
      frame_q        <= '0;
      to_cnt_q       <= '0;
      host_done_q    <= 1'b0;
      host_err_q     <= 1'b0;
      host_rdata_q   <= '0;
      link_up_q      <= 1'b0;
      link_change_q  <= 1'b0;
      poll_data_q    <= '0;
    end else begin
      host_done_q   <= 1'b0;
      link_change_q <= 1'b0;

      if (!bus.POLL_EN) begin
        poll_cnt_q     <= '0;
        poll_pending_q <= 1'b0;
      end else begin
        poll_cnt_q <= poll_expire ? '0 : poll_cnt_q + 1'b1;
        // Expiry while already pending is dropped; a grant clears it.
        if (in_idle && grant_poll) poll_pending_q <= 1'b0;
        else if (poll_expire)      poll_pending_q <= 1'b1;
      end

      if (in_idle && (grant_host || grant_poll)) begin
        owner_host_q <= grant_host;
        owner_wr_q   <= grant_host && bus.HOST_WR;
        last_host_q  <= grant_host;
        if (grant_host) begin
          frame_q <= {2'b01, (bus.HOST_WR ? 2'b01 : 2'b10), bus.HOST_PHYAD, bus.HOST_REGAD,
                      2'b10, (bus.HOST_WR ? bus.HOST_WDATA : 16'h0000)};
        end else begin
          frame_q <= POLL_FRAME;
        end
      end

      if (state_q == StIssue) to_cnt_q <= '0;
      else if (state_q == StWait && !bus.ENG_DONE && !to_last) to_cnt_q <= to_cnt_q + 1'b1;

      if (eng_done_w) begin
        if (owner_host_q) begin
          host_done_q  <= 1'b1;
          host_err_q   <= 1'b0;
          host_rdata_q <= owner_wr_q ? 16'h0000 : bus.ENG_RDATA;
        end else begin
          poll_data_q   <= bus.ENG_RDATA;
          link_up_q     <= bus.ENG_RDATA[LINK_IDX];
          link_change_q <= (bus.ENG_RDATA[LINK_IDX] != link_up_q);
        end
      end else if (timeout_w && owner_host_q) begin
        host_done_q  <= 1'b1;
        host_err_q   <= 1'b1;
        host_rdata_q <= 16'hFFFF;
      end
    end
  end

endmodule

// File: tb/tb_mdio_mgmt_scheduler.sv
module tb_mdio_mgmt_scheduler;
  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  mdio_mgmt_scheduler_if bus();

  mdio_mgmt_scheduler #(
    .POLL_INTERVAL(20),
    .TIMEOUT(TO),
    .POLL_PHYAD(5'd0),
    .POLL_REGAD(5'd1),
    .LINK_BIT(2)
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.HOST_REQ = 0; bus.HOST_WR = 0; bus.HOST_PHYAD = 0; bus.HOST_REGAD = 0;
    bus.HOST_WDATA = 0; bus.POLL_EN = 0; bus.ENG_DONE = 0; bus.ENG_RDATA = 0;
    RESET = 1;
    tick();
    tick();
    RESET = 0;
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (!bus.ENG_START && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic host_issue(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd);
    bus.HOST_REQ = 1; bus.HOST_WR = wr; bus.HOST_PHYAD = phy; bus.HOST_REGAD = rg;
    bus.HOST_WDATA = wd;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.BUSY, bus.HOST_ACK, bus.HOST_DONE, bus.HOST_ERR, bus.LINK_UP, bus.LINK_CHANGE,
         bus.ENG_START} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.BUSY, bus.HOST_ACK, bus.HOST_DONE,
               bus.HOST_ERR, bus.LINK_UP, bus.LINK_CHANGE, bus.ENG_START});
    end
    vectors++;
    if ({bus.HOST_RDATA, bus.POLL_DATA, bus.ENG_FRAME} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {bus.HOST_RDATA, bus.POLL_DATA, bus.ENG_FRAME});
    end
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h5555;
    tick();
    bus.ENG_DONE = 0;
    tick();
    vectors++;
    if ({bus.HOST_DONE, bus.BUSY, bus.ENG_START, bus.HOST_RDATA} !== 19'h0) begin
      miscompares++;
      $display("FAIL idle_done_ignored: got %h want 0",
               {bus.HOST_DONE, bus.BUSY, bus.ENG_START, bus.HOST_RDATA});
    end
  endtask

  task automatic test_host_write();
    int bad;
    host_issue(1'b1, 5'd3, 5'd0, 16'h1140);
    vectors++;
    if ({bus.HOST_ACK, bus.ENG_START, bus.BUSY} !== 3'b111) begin
      miscompares++;
      $display("FAIL wr_issue: got %b want 111", {bus.HOST_ACK, bus.ENG_START, bus.BUSY});
    end
    vectors++;
    if (bus.ENG_FRAME !== 32'h5182_1140) begin
      miscompares++;
      $display("FAIL wr_frame: got %h want 51821140", bus.ENG_FRAME);
    end
    bus.HOST_REQ = 0;
    tick();
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      if (bus.ENG_START || bus.HOST_ACK || bus.HOST_DONE || !bus.BUSY ||
          bus.ENG_FRAME !== 32'h5182_1140) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL wr_wait_stable: got %0d bad cycles want 0", bad);
    end
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'hBEEF;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.HOST_DONE, bus.HOST_ERR, bus.BUSY, bus.HOST_RDATA} !== {3'b100, 16'h0000}) begin
      miscompares++;
      $display("FAIL wr_done: got %h want %h", {bus.HOST_DONE, bus.HOST_ERR, bus.BUSY,
               bus.HOST_RDATA}, {3'b100, 16'h0000});
    end
    tick();
    vectors++;
    if (bus.HOST_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_done_pulse: got %b want 0", bus.HOST_DONE);
    end
  endtask

  task automatic test_host_read();
    host_issue(1'b0, 5'd1, 5'd2, 16'hFFFF);
    vectors++;
    if ({bus.HOST_ACK, bus.ENG_FRAME} !== {1'b1, 32'h608A_0000}) begin
      miscompares++;
      $display("FAIL rd_frame: got %h want 1608a0000", {bus.HOST_ACK, bus.ENG_FRAME});
    end
    bus.HOST_REQ = 0;
    repeat (4) tick();
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h0022;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA} !== {2'b10, 16'h0022}) begin
      miscompares++;
      $display("FAIL rd_done: got %h want %h", {bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA},
               {2'b10, 16'h0022});
    end
  endtask

  task automatic test_timeout();
    int n, bad;
    host_issue(1'b0, 5'd1, 5'd2, 16'h0);
    bus.HOST_REQ = 0;
    tick();
    n = 0; bad = 0;
    while (bus.BUSY && n < 300) begin
      if (bus.HOST_DONE) bad++;
      n++;
      tick();
    end
    vectors++;
    if (n !== TO || bad !== 0) begin
      miscompares++;
      $display("FAIL to_wait_cycles: got %0d (early done %0d) want %0d", n, bad, TO);
    end
    vectors++;
    if ({bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA} !== {2'b11, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL to_abort: got %h want %h", {bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA},
               {2'b11, 16'hFFFF});
    end
    bus.ENG_DONE = 1;
    tick();
    bus.ENG_DONE = 0;
    tick();
    vectors++;
    if ({bus.HOST_DONE, bus.HOST_ERR, bus.BUSY} !== 3'b010) begin
      miscompares++;
      $display("FAIL to_after: got %b want 010", {bus.HOST_DONE, bus.HOST_ERR, bus.BUSY});
    end
  endtask

  // Completion in the very last WAIT cycle must beat the timeout.
  task automatic test_done_wins();
    host_issue(1'b0, 5'd1, 5'd2, 16'h0);
    bus.HOST_REQ = 0;
    tick();
    repeat (TO - 1) tick();
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'hA5A5;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA} !== {2'b10, 16'hA5A5}) begin
      miscompares++;
      $display("FAIL done_wins: got %h want %h", {bus.HOST_DONE, bus.HOST_ERR, bus.HOST_RDATA},
               {2'b10, 16'hA5A5});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_host;
    logic [31:0] exp_frame;
    do_reset();
    bus.POLL_EN = 1;
    bus.HOST_REQ = 1; bus.HOST_WR = 0; bus.HOST_PHYAD = 5'd7; bus.HOST_REGAD = 5'd4;
    for (int i = 0; i < 4; i++) begin
      wait_start(100, n);
      exp_host  = (i % 2 == 0);
      exp_frame = exp_host ? 32'h6392_0000 : 32'h6006_0000;
      vectors++;
      if (n >= 100 || bus.HOST_ACK !== exp_host || bus.ENG_FRAME !== exp_frame) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got ack=%b frame=%h wait=%0d want ack=%b frame=%h", i,
                 bus.HOST_ACK, bus.ENG_FRAME, n, exp_host, exp_frame);
      end
      tick();
      repeat (24) tick();
      bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h0000;
      tick();
      bus.ENG_DONE = 0;
    end
    bus.HOST_REQ = 0; bus.POLL_EN = 0;
    repeat (4) tick();
  endtask

  task automatic test_poll_link();
    int n, starts;
    do_reset();
    bus.POLL_EN = 1;
    wait_start(100, n);
    vectors++;
    if (n !== 21 || bus.HOST_ACK !== 1'b0 || bus.ENG_FRAME !== 32'h6006_0000) begin
      miscompares++;
      $display("FAIL poll_first: got wait=%0d ack=%b frame=%h want wait=21 ack=0 frame=60060000",
               n, bus.HOST_ACK, bus.ENG_FRAME);
    end
    tick();
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h0004;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA} !== {2'b11, 16'h0004}) begin
      miscompares++;
      $display("FAIL poll_up: got %h want %h", {bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA},
               {2'b11, 16'h0004});
    end
    tick();
    vectors++;
    if ({bus.LINK_UP, bus.LINK_CHANGE} !== 2'b10) begin
      miscompares++;
      $display("FAIL poll_change_pulse: got %b want 10", {bus.LINK_UP, bus.LINK_CHANGE});
    end
    // Poll that times out leaves the link status alone.
    wait_start(100, n);
    tick();
    n = 0;
    while (bus.BUSY && n < 300) begin
      n++;
      tick();
    end
    vectors++;
    if (n !== TO || {bus.LINK_UP, bus.LINK_CHANGE, bus.HOST_DONE, bus.POLL_DATA} !==
        {3'b100, 16'h0004}) begin
      miscompares++;
      $display("FAIL poll_abort: got wait=%0d %h want wait=%0d %h", n, {bus.LINK_UP,
               bus.LINK_CHANGE, bus.HOST_DONE, bus.POLL_DATA}, TO, {3'b100, 16'h0004});
    end
    wait_start(100, n);
    tick();
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h0100;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA} !== {2'b01, 16'h0100}) begin
      miscompares++;
      $display("FAIL poll_down: got %h want %h", {bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA},
               {2'b01, 16'h0100});
    end
    wait_start(100, n);
    tick();
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h0000;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA} !== {2'b00, 16'h0000}) begin
      miscompares++;
      $display("FAIL poll_same: got %h want %h", {bus.LINK_UP, bus.LINK_CHANGE, bus.POLL_DATA},
               {2'b00, 16'h0000});
    end
    bus.POLL_EN = 0;
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ENG_START) starts++;
      tick();
    end
    vectors++;
    if (starts !== 0) begin
      miscompares++;
      $display("FAIL poll_disabled: got %0d starts want 0", starts);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    host_issue(1'b0, 5'd2, 5'd3, 16'h0);
    bus.HOST_REQ = 0;
    tick();
    repeat (5) tick();
    RESET = 1;
    tick();
    RESET = 0;
    vectors++;
    if ({bus.BUSY, bus.HOST_DONE, bus.ENG_START, bus.ENG_FRAME} !== 35'h0) begin
      miscompares++;
      $display("FAIL rst_wait: got %h want 0", {bus.BUSY, bus.HOST_DONE, bus.ENG_START,
               bus.ENG_FRAME});
    end
    bus.ENG_DONE = 1; bus.ENG_RDATA = 16'h1234;
    tick();
    bus.ENG_DONE = 0;
    vectors++;
    if ({bus.HOST_DONE, bus.BUSY, bus.HOST_RDATA} !== 18'h0) begin
      miscompares++;
      $display("FAIL rst_late_done: got %h want 0", {bus.HOST_DONE, bus.BUSY, bus.HOST_RDATA});
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_read();
    test_timeout();
    test_done_wins();
    test_back_to_back();
    test_poll_link();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
